// File: rtl/muldiv_iterative.sv
// -----------------------------------------------------------------------------
// muldiv_iterative
//   Iterative RV32M multiply/divide unit. Accepts one operation at a time,
//   computes one result bit per cycle (shift-add for MUL*, restoring
//   shift-subtract for DIV*/REM*), and produces a single register-file
//   write-back per operation. Divide-by-zero and signed overflow skip the
//   iteration and complete in the cycle after accept.
//
// Ports
//   clk          rising-edge clock
//   async_reset  synchronous active-high reset
//   start        issue operation (accepted only when idle)
//   funct3       000 MUL 001 MULH 010 MULHSU 011 MULHU
//                100 DIV 101 DIVU 110 REM  111 REMU
//   rs1_val      operand A / dividend
//   rs2_val      operand B / divisor
//   rd_addr_in   destination register
//   flush        abort any in-flight operation (wins over start)
//   busy         high from the cycle after accept through the result cycle
//   done         one-cycle pulse in the result cycle
//   wb_en        register-file write enable (done && wb_addr != 0)
//   wb_addr      latched destination register
//   wb_data      result, held until the next done
// -----------------------------------------------------------------------------
module muldiv_iterative #(
  parameter int bits           = 32,
  parameter int reg_addr_width = 5
) (
  input  logic                      clk,
  input  logic                      async_reset,
  input  logic                      start,
  input  logic [2:0]                funct3,
  input  logic [bits-1:0]           rs1_val,
  input  logic [bits-1:0]           rs2_val,
  input  logic [reg_addr_width-1:0] rd_addr_in,
  input  logic                      flush,
  output logic                      busy,
  output logic                      done,
  output logic                      wb_en,
  output logic [reg_addr_width-1:0] wb_addr,
  output logic [bits-1:0]           wb_data
);

  localparam int CW = $clog2(bits);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [bits-1:0] INT_MIN  = {1'b1, {(bits-1){1'b0}}};
  localparam logic [bits-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Two's complement conditional negation on a result word.
  function automatic logic [bits-1:0] cond_neg_w(input logic [bits-1:0] v,
                                                 input logic            n);
    return n ? -v : v;
  endfunction

  // Two's complement conditional negation on the double-width product.
  function automatic logic [2*bits-1:0] cond_neg_2w(input logic [2*bits-1:0] v,
                                                    input logic              n);
    return n ? -v : v;
  endfunction

  // ---------------------------------------------------------------------------
  // State and next-state registers
  // ---------------------------------------------------------------------------
  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [2:0]                op_q, op_d;
  logic [2*bits-1:0]         acc_q, acc_d;   // {hi, lo}: product or {rem, quotient}
  logic [bits-1:0]           b_q, b_d;       // |multiplicand| or |divisor|
  logic                      neg_q, neg_d;   // product / quotient sign
  logic                      rneg_q, rneg_d; // remainder sign (dividend sign)
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      wb_en_q, wb_en_d;
  logic [reg_addr_width-1:0] wb_addr_q, wb_addr_d;
  logic [bits-1:0]           wb_data_q, wb_data_d;

  // Operand conditioning at accept
  logic            a_signed, b_signed, sa, sb, is_div;
  logic [bits-1:0] abs_a, abs_b;

  // One iteration step
  logic [bits-1:0]   hi, lo;
  logic [bits:0]     mul_sum;
  logic [bits:0]     r_sh, r_diff;
  logic              r_ge;
  logic [2*bits-1:0] acc_step;
  logic [2*bits-1:0] prod;
  logic [bits-1:0]   result;

  always_comb begin
    is_div   = funct3[2];
    // MUL's low word is sign-agnostic, so it runs on raw operands.
    a_signed = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
               (funct3 == OP_DIV)  || (funct3 == OP_REM);
    b_signed = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
    sa       = a_signed & rs1_val[bits-1];
    sb       = b_signed & rs2_val[bits-1];
    abs_a    = cond_neg_w(rs1_val, sa);
    abs_b    = cond_neg_w(rs2_val, sb);
  end

  always_comb begin
    hi      = acc_q[2*bits-1:bits];
    lo      = acc_q[bits-1:0];
    // Shift-add: add multiplicand when the current multiplier LSB is set,
    // then shift the whole {carry, hi, lo} right by one.
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    // Restoring divide: shift next dividend bit into the remainder and try
    // the subtraction; the borrow bit tells whether it fits.
    r_sh    = {hi, lo[bits-1]};
    r_diff  = r_sh - {1'b0, b_q};
    r_ge    = ~r_diff[bits];
    if (op_q[2])
      acc_step = {(r_ge ? r_diff[bits-1:0] : r_sh[bits-1:0]), lo[bits-2:0], r_ge};
    else
      acc_step = {mul_sum, lo[bits-1:1]};

    // Final sign fix-up and word select, applied to the last step's value so
    // the result is registered on entry to DONE.
    prod = cond_neg_2w(acc_step, neg_q);
    if (op_q[2]) begin
      if (op_q[1])
        result = cond_neg_w(acc_step[2*bits-1:bits], rneg_q);
      else
        result = cond_neg_w(acc_step[bits-1:0], neg_q);
    end else if (op_q == OP_MUL) begin
      result = prod[bits-1:0];
    end else begin
      result = prod[2*bits-1:bits];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    b_d       = b_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;

    if (flush) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            op_d      = funct3;
            wb_addr_d = rd_addr_in;
            busy_d    = 1'b1;
            if (is_div && (rs2_val == '0)) begin
              state_d   = DONE;
              done_d    = 1'b1;
              wb_en_d   = (rd_addr_in != '0);
              wb_data_d = funct3[1] ? rs1_val : ALL_ONES;
            end else if (((funct3 == OP_DIV) || (funct3 == OP_REM)) &&
                         (rs1_val == INT_MIN) && (rs2_val == ALL_ONES)) begin
              state_d   = DONE;
              done_d    = 1'b1;
              wb_en_d   = (rd_addr_in != '0);
              wb_data_d = funct3[1] ? '0 : INT_MIN;
            end else begin
              // Both algorithms start with |A| in the low half and zero above.
              state_d = CALC;
              cnt_d   = CW'(bits - 1);
              acc_d   = {{bits{1'b0}}, abs_a};
              b_d     = abs_b;
              neg_d   = sa ^ sb;
              rneg_d  = sa;
            end
          end
        end
        CALC: begin
          acc_d = acc_step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d   = DONE;
            done_d    = 1'b1;
            wb_en_d   = (wb_addr_q != '0);
            wb_data_d = result;
          end
        end
        DONE: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (async_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wb_en   = wb_en_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;

endmodule

// File: tb/tb_muldiv_iterative.sv
// -----------------------------------------------------------------------------
// tb_muldiv_iterative
//   Directed bench for muldiv_iterative. Expected write-backs are queued at
//   issue and popped by a monitor whenever done is seen; the directed
//   sequence checks latency, busy, flush, re-start, rd=0 and reset.
// -----------------------------------------------------------------------------
module tb_muldiv_iterative;

  localparam int W  = 32;
  localparam int AW = 5;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic          clk;
  logic          async_reset;
  logic          start;
  logic [2:0]    funct3;
  logic [W-1:0]  rs1_val, rs2_val;
  logic [AW-1:0] rd_addr_in;
  logic          flush;
  logic          busy, done, wb_en;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;

  muldiv_iterative #(.bits(W), .reg_addr_width(AW)) dut (
    .clk        (clk),
    .async_reset(async_reset),
    .start      (start),
    .funct3     (funct3),
    .rs1_val    (rs1_val),
    .rs2_val    (rs2_val),
    .rd_addr_in (rd_addr_in),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic          en;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("wb_addr", 64'(wb_addr), 64'(mon_e.addr));
        check("wb_data", 64'(wb_data), 64'(mon_e.data));
        check("wb_en",   64'(wb_en),   64'(mon_e.en));
      end
    end
  end

  // Drive an operation at the current (negedge) time; optionally queue result.
  task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [AW-1:0] rd, input bit push, input logic [W-1:0] exp_data);
    exp_t e;
    start      = 1'b1;
    funct3     = f;
    rs1_val    = a;
    rs2_val    = b;
    rd_addr_in = rd;
    if (push) begin
      e.addr = rd;
      e.data = exp_data;
      e.en   = (rd != '0);
      sb.push_back(e);
    end
  endtask

  // Called at the negedge of cycle k0 after accept; waits (bounded) for done.
  task automatic wait_done(input string tag, input int k0, input int lat);
    int k;
    k = k0;
    while (done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'(lat));
  endtask

  task automatic run(input string tag, input logic [2:0] f, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [AW-1:0] rd,
                     input logic [W-1:0] exp_data, input int lat);
    @(negedge clk);
    issue(f, a, b, rd, 1'b1, exp_data);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(tag, 1, lat);
  endtask

  initial begin
    async_reset = 1'b1;
    start       = 1'b0;
    flush       = 1'b0;
    funct3      = '0;
    rs1_val     = '0;
    rs2_val     = '0;
    rd_addr_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",    64'(busy),    64'd0);
    check("rst_done",    64'(done),    64'd0);
    check("rst_wb_en",   64'(wb_en),   64'd0);
    check("rst_wb_addr", 64'(wb_addr), 64'd0);
    check("rst_wb_data", 64'(wb_data), 64'd0);
    async_reset = 1'b0;

    // Multiply
    run("mul",    MUL,    32'd7,        32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33);
    @(negedge clk);
    check("busy_after_done", 64'(busy), 64'd0);
    run("mulhu",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 33);
    run("mulh",   MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, 33);
    run("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd8, 32'hFFFF_FFFF, 33);
    run("mulh_mix", MULH, 32'h8000_0000, 32'd3,         5'd9, 32'hFFFF_FFFE, 33);

    // Divide
    run("div",  DIV,  32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 33);
    run("rem",  REM,  32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 33);
    run("divu", DIVU, 32'd100,       32'd7, 5'd12, 32'd14,        33);
    run("remu", REMU, 32'd100,       32'd7, 5'd13, 32'd2,         33);

    // Special cases bypass the iteration
    run("divu0",  DIVU, 32'h1234,      32'd0,         5'd14, 32'hFFFF_FFFF, 1);
    run("remu0",  REMU, 32'h1234,      32'd0,         5'd15, 32'h1234,      1);
    run("div_ov", DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1);
    run("rem_ov", REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, 1);
    run("div0",   DIV,  32'hFFFF_FFF0, 32'd0,         5'd18, 32'hFFFF_FFFF, 1);

    // Flush at cycle 10 of a DIV, then a fresh start at cycle 11
    @(negedge clk);
    issue(DIV, 32'd1000, 32'd3, 5'd19, 1'b0, '0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    issue(DIVU, 32'd100, 32'd7, 5'd20, 1'b1, 32'd14);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done("flush_restart", 12, 44);

    // start re-pulsed with new operands at cycle 5 is ignored
    @(negedge clk);
    issue(MUL, 32'd6, 32'd7, 5'd3, 1'b1, 32'd42);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start      = 1'b1;
    funct3     = DIV;
    rs1_val    = 32'd99;
    rs2_val    = 32'd5;
    rd_addr_in = 5'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done("repulse", 6, 33);

    // rd = 0: done pulses, no write enable, data still updated
    run("rd0", MUL, 32'd3, 32'd3, 5'd0, 32'd9, 33);

    // Reset at cycle 20 of an operation
    @(negedge clk);
    issue(MULHU, 32'd5, 32'd5, 5'd4, 1'b0, '0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    async_reset = 1'b1;
    @(negedge clk);
    async_reset = 1'b0;
    check("mrst_busy",    64'(busy),    64'd0);
    check("mrst_done",    64'(done),    64'd0);
    check("mrst_wb_en",   64'(wb_en),   64'd0);
    check("mrst_wb_addr", 64'(wb_addr), 64'd0);
    check("mrst_wb_data", 64'(wb_data), 64'd0);

    run("post_reset", REMU, 32'd100, 32'd7, 5'd2, 32'd2, 33);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
